// File: rtl/bf4_pkg.sv
// Shared constants for the radix-4 butterfly datapath.
// Used by the butterfly stage and by the bin serializer that follows it.
//   NBIN       bins per butterfly frame
//   BIN_IDX_W  width of a bin index
//   DEFAULT_DW default signed component width of a bin
//   LAST_IDX   index of the final bin in a frame
package bf4_pkg;
  localparam int NBIN       = 4;
  localparam int BIN_IDX_W  = 2;
  localparam int DEFAULT_DW = 16;

  localparam logic [BIN_IDX_W-1:0] LAST_IDX = BIN_IDX_W'(NBIN - 1);
endpackage

// File: rtl/bf4_frame_fifo.sv
// Frame buffer for the bin serializer: DEPTH slots of one whole butterfly frame each.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   flush      synchronous clear of pointers and count; wins over push and pop
//   push/wdata write wdata into slot wr_ptr (ignored when full)
//   pop        retire slot rd_ptr (ignored when empty)
//   rdata      contents of slot rd_ptr, valid while ~empty
//   empty/full occupancy flags
module bf4_frame_fifo
  import bf4_pkg::*;
#(
  parameter int W     = 2 * NBIN * DEFAULT_DW,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign wr_en = push & ~full & ~flush;
  assign rd_en = pop & ~empty & ~flush;
  assign rdata = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; validity is tracked by count,
  // so clearing the array would only cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bf4_bin_serializer.sv
// Bin serializer: accepts one 4-bin complex frame per handshake, buffers DEPTH frames,
// and streams each frame out one bin per beat with its index and a last flag.
// Optional feature macro: BIN_MAG_EN adds out_mag = |out_re| + |out_im| (DW+1 bits).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                synchronous clear of all buffered frames
//   in_valid/in_ready    frame handshake for re_0..re_3 / im_0..im_3 (signed DW)
//   out_valid/out_ready  bin handshake
//   out_re/out_im        current bin components
//   out_idx/out_last     current bin index, high on bin 3
//   out_mag              (BIN_MAG_EN only) unsigned magnitude sum of the current bin
module bf4_bin_serializer
  import bf4_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] re_0,
  input  logic signed [DW-1:0] re_1,
  input  logic signed [DW-1:0] re_2,
  input  logic signed [DW-1:0] re_3,
  input  logic signed [DW-1:0] im_0,
  input  logic signed [DW-1:0] im_1,
  input  logic signed [DW-1:0] im_2,
  input  logic signed [DW-1:0] im_3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [BIN_IDX_W-1:0] out_idx,
  output logic                 out_last
`ifdef BIN_MAG_EN
  ,
  output logic [DW:0]          out_mag
`endif
);
  localparam int FW = 2 * NBIN * DW;

  logic [FW-1:0]        wdata;
  logic [FW-1:0]        rdata;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 beat;
  logic                 pop;
  logic [BIN_IDX_W-1:0] bin;
  logic [DW-1:0]        sel_re;
  logic [DW-1:0]        sel_im;

  // Slot layout: re_k at word k, im_k at word NBIN+k.
  assign wdata = {im_3, im_2, im_1, im_0, re_3, re_2, re_1, re_0};

  // Ready is blocked during reset and flush so neither can swallow a frame.
  assign in_ready  = ~rst & ~full & ~flush;
  assign push      = in_valid & in_ready;
  assign out_valid = ~empty;
  assign beat      = out_valid & out_ready;
  assign pop       = beat & (bin == LAST_IDX);

  bf4_frame_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .empty (empty),
    .full  (full)
  );

  // Bin counter wraps 3 -> 0 on its own; the FIFO retires the slot on that beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        bin <= '0;
    else if (flush) bin <= '0;
    else if (beat)  bin <= bin + 1'b1;
  end

  // The counter is always 0 while the FIFO is empty, so idx/last need no gating.
  // Data is forced to zero when empty because the unreset storage may hold anything.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_re = '0;
    sel_im = '0;
    out_re = '0;
    out_im = '0;
    sel_re = rdata[int'(bin) * DW +: DW];
    sel_im = rdata[(NBIN + int'(bin)) * DW +: DW];
    if (out_valid) begin
      out_re = sel_re;
      out_im = sel_im;
    end
  end

  assign out_idx  = bin;
  assign out_last = (bin == LAST_IDX);

`ifdef BIN_MAG_EN
  // Absolute values are taken in DW+1 bits so abs(-2^(DW-1)) is representable;
  // the sum peaks at 2^DW and still fits.
  logic signed [DW:0] ext_re;
  logic signed [DW:0] ext_im;
  logic [DW:0]        abs_re;
  logic [DW:0]        abs_im;

  assign ext_re  = {out_re[DW-1], out_re};
  assign ext_im  = {out_im[DW-1], out_im};
  assign abs_re  = ext_re[DW] ? -ext_re : ext_re;
  assign abs_im  = ext_im[DW] ? -ext_im : ext_im;
  assign out_mag = abs_re + abs_im;
`endif
endmodule

// File: tb/tb_bf4_bin_serializer.sv
// Self-checking bench for bf4_bin_serializer (DW=16, DEPTH=2).
// Directed frames feed a source queue; accepted frames are expanded into an expected
// beat queue that every presented output beat is compared against.
module tb_bf4_bin_serializer;
  typedef struct packed {
    logic [3:0][15:0] re;
    logic [3:0][15:0] im;
  } frame_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] re_0, re_1, re_2, re_3;
  logic [15:0] im_0, im_1, im_2, im_3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [1:0]  out_idx;
  logic        out_last;
`ifdef BIN_MAG_EN
  logic [16:0] out_mag;
`endif

  int total = 0;
  int bad   = 0;
  bit rand_ready = 1'b0;

  frame_t src_q[$];
  beat_t  exp_q[$];

  bf4_bin_serializer #(.DW(16), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .re_0      (re_0),
    .re_1      (re_1),
    .re_2      (re_2),
    .re_3      (re_3),
    .im_0      (im_0),
    .im_1      (im_1),
    .im_2      (im_2),
    .im_3      (im_3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef BIN_MAG_EN
    ,
    .out_mag   (out_mag)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input int base);
    frame_t f;
    for (int k = 0; k < 4; k++) begin
      f.re[k] = 16'(base + k);
      f.im[k] = 16'(-(base + k));
    end
    return f;
  endfunction

  function automatic logic [16:0] absv(input logic [15:0] v);
    return v[15] ? 17'(17'd0 - {1'b1, v}) : {1'b0, v};
  endfunction

  task automatic drive_inputs();
    frame_t f;
    in_valid = (src_q.size() != 0);
    if (src_q.size() != 0) begin
      f = src_q[0];
      re_0 = f.re[0]; re_1 = f.re[1]; re_2 = f.re[2]; re_3 = f.re[3];
      im_0 = f.im[0]; im_1 = f.im[1]; im_2 = f.im[2]; im_3 = f.im[3];
    end
  endtask

  // One clock: compare the presented beat, advance the model across the edge,
  // then drive the next inputs. Returns 2 time units after the rising edge.
  task automatic tick();
    logic  acc;
    logic  bt;
    beat_t b;
    @(negedge clk);
    if (out_valid) begin
      check("sb_beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("sb_idx",  64'(out_idx),  64'(exp_q[0].idx));
        check("sb_re",   64'(out_re),   64'(exp_q[0].re));
        check("sb_im",   64'(out_im),   64'(exp_q[0].im));
        check("sb_last", 64'(out_last), 64'(exp_q[0].last));
`ifdef BIN_MAG_EN
        check("sb_mag", 64'(out_mag), 64'(absv(exp_q[0].re) + absv(exp_q[0].im)));
`endif
      end
    end
    acc = in_valid & in_ready;
    bt  = out_valid & out_ready;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (bt && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc && src_q.size() != 0) begin
        for (int k = 0; k < 4; k++) begin
          b.idx  = 2'(k);
          b.re   = src_q[0].re[k];
          b.im   = src_q[0].im[k];
          b.last = (k == 3);
          exp_q.push_back(b);
        end
        void'(src_q.pop_front());
      end
    end
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    drive_inputs();
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 64'(exp_q.size() + src_q.size()), 64'd0);
  endtask

  beat_t  vec [4];
  frame_t fr;

  initial begin
    // Hand-computed beats for frame re={100,-50,0,-25}, im={0,-7,0,7}.
    vec[0] = '{idx: 2'd0, re: 16'(100), im: 16'(0),  last: 1'b0};
    vec[1] = '{idx: 2'd1, re: 16'(-50), im: 16'(-7), last: 1'b0};
    vec[2] = '{idx: 2'd2, re: 16'(0),   im: 16'(0),  last: 1'b0};
    vec[3] = '{idx: 2'd3, re: 16'(-25), im: 16'(7),  last: 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    re_0 = '0; re_1 = '0; re_2 = '0; re_3 = '0;
    im_0 = '0; im_1 = '0; im_2 = '0; im_3 = '0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_re",    64'(out_re),    64'd0);
    check("rst_out_idx",   64'(out_idx),   64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // 1: single frame, unstalled
    out_ready = 1'b1;
    fr.re = {16'(-25), 16'(0), 16'(-50), 16'(100)};
    fr.im = {16'(7),   16'(0), 16'(-7),  16'(0)};
    src_q.push_back(fr);
    drive_inputs(); #1;
    check("t1_no_passthru", 64'(out_valid), 64'd0);
    tick();
    check("t1_latency", 64'(out_valid), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("t1_idx",  64'(out_idx),  64'(vec[k].idx));
      check("t1_re",   64'(out_re),   64'(vec[k].re));
      check("t1_im",   64'(out_im),   64'(vec[k].im));
      check("t1_last", 64'(out_last), 64'(vec[k].last));
      tick();
    end
    check("t1_empty", 64'(out_valid), 64'd0);

    // 2: three frames into a stalled consumer
    out_ready = 1'b0;
    src_q.push_back(mk(10));
    src_q.push_back(mk(20));
    src_q.push_back(mk(30));
    drive_inputs(); #1;
    tick();
    tick();
    check("t2_full_ready", 64'(in_ready), 64'd0);
    tick();
    check("t2_full_hold",  64'(in_ready),  64'd0);
    check("t2_valid",      64'(out_valid), 64'd1);
    check("t2_first_re",   64'(out_re),    64'd10);
    out_ready = 1'b1; #1;
    tick(); tick(); tick();
    check("t2_idx3",       64'(out_idx),  64'd3);
    check("t2_still_full", 64'(in_ready), 64'd0);
    tick();
    check("t2_reopen", 64'(in_ready), 64'd1);
    drain(40);
    check("t2_empty", 64'(out_valid), 64'd0);

    // 3: random consumer stalls; scoreboard checks hold and order every cycle
    for (int i = 0; i < 3; i++) begin
      fr.re = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      fr.im = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      src_q.push_back(fr);
    end
    rand_ready = 1'b1;
    drive_inputs(); #1;
    for (int i = 0; i < 40; i++) tick();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain(60);
    check("t3_empty", 64'(out_valid), 64'd0);

    // 4: push accepted on the same edge as the final-bin pop with count=1
    src_q.push_back(mk(40));
    drive_inputs(); #1;
    tick(); tick(); tick(); tick();
    src_q.push_back(mk(50));
    drive_inputs(); #1;
    check("t4_idx3",  64'(out_idx),  64'd3);
    check("t4_ready", 64'(in_ready), 64'd1);
    tick();
    check("t4_next_valid", 64'(out_valid), 64'd1);
    check("t4_next_idx",   64'(out_idx),   64'd0);
    check("t4_next_re",    64'(out_re),    64'd50);
    check("t4_not_full",   64'(in_ready),  64'd1);
    tick(); tick(); tick(); tick();
    check("t4_count_one", 64'(out_valid), 64'd0);

    // 5: flush mid-frame with two frames buffered and a push pending
    out_ready = 1'b0;
    src_q.push_back(mk(60));
    src_q.push_back(mk(70));
    drive_inputs(); #1;
    tick(); tick();
    src_q.push_back(mk(80));
    out_ready = 1'b1;
    drive_inputs(); #1;
    tick(); tick();
    out_ready = 1'b0;
    flush = 1'b1; #1;
    check("t5_idx2",        64'(out_idx),  64'd2);
    check("t5_flush_block", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; #1;
    check("t5_valid_low", 64'(out_valid), 64'd0);
    check("t5_idx_clr",   64'(out_idx),   64'd0);
    check("t5_ready_back", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("t5_fresh_valid", 64'(out_valid), 64'd1);
    check("t5_fresh_idx",   64'(out_idx),   64'd0);
    check("t5_fresh_re",    64'(out_re),    64'd80);
    drain(20);

    // 6: extreme magnitude and async reset mid-frame
    fr.re = {16'd3, 16'd2, 16'h7FFF, 16'h8000};
    fr.im = {16'd3, 16'd2, 16'h8000, 16'h8000};
    src_q.push_back(fr);
    drive_inputs(); #1;
    tick();
`ifdef BIN_MAG_EN
    check("t6_mag_max", 64'(out_mag), 64'h10000);
`endif
    tick();
    check("t6_mid_idx", 64'(out_idx), 64'd1);
    rst = 1'b1; #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_re",    64'(out_re),    64'd0);
    check("t6_rst_im",    64'(out_im),    64'd0);
    check("t6_rst_idx",   64'(out_idx),   64'd0);
    check("t6_rst_last",  64'(out_last),  64'd0);
    check("t6_rst_ready", 64'(in_ready),  64'd0);
`ifdef BIN_MAG_EN
    check("t6_rst_mag", 64'(out_mag), 64'd0);
`endif
    exp_q.delete();
    src_q.delete();
    drive_inputs();
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("t6_rel_ready", 64'(in_ready), 64'd1);
    src_q.push_back(mk(90));
    drive_inputs(); #1;
    drain(20);
    tick();
    check("t6_final_empty", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
